uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  8N1 UART receiver; the receive-side counterpart of the TX transmitter in the UART project.
//  Samples serial line rx at mid-bit using a clock-cycle baud counter.
//  Presents each received byte on data_out with a one-cycle rx_done strobe.
//  Flags bad stop bits (framing error) and then waits for the line to return idle (high).
// PARAMETERS
//  CLKS_PER_BIT  16  clock cycles per bit; must be >= 4 and even
// PORTS
//  clock      in   1  system clock, rising-edge
//  reset      in   1  synchronous, active-high reset
//  rx         in   1  asynchronous serial input, idle high
//  data_out   out  8  last correctly framed byte, LSB received first
//  rx_done    out  1  1-cycle pulse: data_out updated this cycle
//  frame_err  out  1  1-cycle pulse: stop bit sampled low
//  busy       out  1  high in any state other than IDLE
// BEHAVIOUR
//  Clocking and reset
//  - One clock domain. Reset is synchronous and active-high.
//  - Reset values: data_out=8'h00, rx_done=0, frame_err=0, busy=0, state=IDLE.
//  - Reset: counters=0, and both synchroniser flops=1.
//  - Reset mid-frame abandons the frame; no rx_done or frame_err is produced for it.
//  Input synchroniser
//  - rx goes through 2 flops before use; rxs is the 2nd flop.
//  - Everything below uses only rxs.
//  Counters
//  - cnt runs from 0 to CLKS_PER_BIT-1. bit_idx runs from 0 to 7 (3 bits).
//  - cnt clears on every state change.
//  FSM states: IDLE, START, DATA, STOP, BREAK
//  - IDLE: when rxs==0, go to START with cnt=0.
//  - START: increment cnt. At cnt==CLKS_PER_BIT/2-1, sample rxs.
//    - rxs==0: go to DATA, bit_idx=0.
//    - rxs==1: glitch; go back to IDLE with no output pulse.
//  - DATA: increment cnt. At cnt==CLKS_PER_BIT-1, shift rxs into shreg[bit_idx] (LSB first).
//    - bit_idx==7: go to STOP. Otherwise increment bit_idx.
//  - STOP: at cnt==CLKS_PER_BIT-1, sample rxs.
//    - rxs==1: data_out<=shreg, rx_done=1 for 1 cycle, go to IDLE.
//    - rxs==0: frame_err=1 for 1 cycle, data_out unchanged, go to BREAK.
//  - BREAK: stay until rxs==1, then go to IDLE. Line held low gives exactly one frame_err.
//  Timing and outputs
//  - Sampling points are mid-bit. Stop bit is sampled at start edge + 9.5 bit times.
//  - rx_done/frame_err latency: CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3 cycles (+/-1) after rx falls.
//  - Back-to-back frames: a new start bit may follow immediately.
//    IDLE is re-entered the cycle after the stop sample, so no gap cycle is needed.
//  - rx_done and frame_err are never both high. data_out holds until the next good frame.
//  - busy = (state != IDLE). It stays high through BREAK.
// TESTING  (CLKS_PER_BIT=16, clock period 5)
//  T1 reset: hold reset 3 cycles with rx=1.
//     -> data_out=00, rx_done=0, frame_err=0, busy=0.
//  T2 single byte: drive 8'b11001001 (LSB first, 16 clks/bit, stop=1).
//     -> exactly one rx_done at ~155 cycles after start edge; data_out=C9; frame_err never high.
//  T3 back-to-back bytes: send 8'h6D then 8'h00 with no idle gap.
//     -> two rx_done pulses, data_out 6D then 00.
//  T4 glitch: pulse rx low for 4 cycles only.
//     -> return to IDLE, no rx_done/frame_err; a following 8'hA5 is still received correctly.
//  T5 framing error: send 8'h3C with stop=0, hold rx low 100 cycles, then release.
//     -> one frame_err pulse; data_out keeps its old value; busy high until rx high.
//     -> next 8'h55 is received OK.
//  T6 reset mid-frame: assert reset during bit 4 of 8'hFF, then send 8'h81.
//     -> no pulse for the aborted frame; rx_done with data_out=81.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling from a clock-cycle baud counter.
// Byte lands on data_out with a 1-cycle rx_done; a low stop bit pulses frame_err and waits for idle.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rxs;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [7:0]    data_nxt;
  logic          done_nxt, ferr_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data_out  <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rxs       <= rx_meta;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shreg     <= shreg_nxt;
      data_out  <= data_nxt;
      rx_done   <= done_nxt;
      frame_err <= ferr_nxt;
    end
  end

  // Every transition below forces cnt back to zero.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    data_nxt    = data_out;
    done_nxt    = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) state_nxt = START;
      end
      START: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_MID) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_nxt            = '0;
          shreg_nxt[bit_idx] = rxs;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      STOP: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (rxs) begin
            data_nxt  = shreg;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: stimulus pushes expected pulses into a queue, a negedge monitor pops and checks.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       rx_done, frame_err, busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .rx(rx),
    .data_out(data_out), .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
  );

  always #2.5 clock = ~clock;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drives one frame; rx is left at the stop level on return.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_t e;
    e.err   = !stop;
    e.data  = stop ? d : last_good;
    e.start = cyc;
    exp_q.push_back(e);
    if (stop) last_good = d;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clock) begin
    if (!reset && (rx_done || frame_err)) begin
      check("pulse_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got rx_done=%0b frame_err=%0b, expected none (cycle %0d)",
                 rx_done, frame_err, cyc);
      end else begin
        exp_t e;
        int   lat;
        e   = exp_q.pop_front();
        lat = cyc - e.start;
        check(e.err ? "frame_err_kind" : "rx_done_kind", {31'd0, frame_err}, {31'd0, e.err});
        check("data_out", {24'd0, data_out}, {24'd0, e.data});
        n_checks++;
        if (lat < 153 || lat > 157) begin
          n_fail++;
          $display("FAIL latency: got %0d cycles, expected 153..157 (cycle %0d)", lat, cyc);
        end
      end
    end
  end

  initial begin
    // T1 reset
    rx = 1'b1;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("reset_data_out", {24'd0, data_out}, 32'h00);
    check("reset_rx_done", {31'd0, rx_done}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    tick(10);

    // T2 single byte
    send_frame(8'hC9, 1'b1);
    tick(20);

    // T3 back-to-back, no idle gap between stop and next start
    send_frame(8'h6D, 1'b1);
    send_frame(8'h00, 1'b1);
    tick(20);

    // T4 glitch then a real byte
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(20);
    check("glitch_idle_busy", {31'd0, busy}, 32'd0);
    send_frame(8'hA5, 1'b1);
    tick(20);

    // T5 framing error, line held low, busy through BREAK
    send_frame(8'h3C, 1'b0);
    tick(84);
    check("break_busy", {31'd0, busy}, 32'd1);
    check("break_data_out", {24'd0, data_out}, 32'hA5);
    rx = 1'b1;
    tick(4);
    check("break_released_busy", {31'd0, busy}, 32'd0);
    tick(20);
    send_frame(8'h55, 1'b1);
    tick(20);

    // T6 reset during bit 4 of 8'hFF
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(4 * CPB + CPB / 2);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("midframe_reset_busy", {31'd0, busy}, 32'd0);
    check("midframe_reset_data_out", {24'd0, data_out}, 32'h00);
    tick(20);
    send_frame(8'h81, 1'b1);

    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
    tick(200);
    check("pending_expectations", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
